vend_controller: RTL and testbench
==================================

// Module: vend_controller
// PURPOSE
//  Parametrised successor to the single-drink coin/compare/FSM path. Accepts two coin denominations,
//  accumulates saturating credit, vends one of N_PROD products by price, returns change as coins.
//  Refunds on cancel or inactivity timeout. Sits between the Debouncer outputs (coin pulses,
//  selection levels) and the ingredient LEDs / seven_segment credit display.
// PARAMETERS
//  N_PROD        4                  number of selectable products
//  CREDIT_W      8                  width of credit/price/change values (units of low coin)
//  COIN_HI_VAL   5                  value of high coin in low-coin units (low coin = 1)
//  MAX_CREDIT    99                 credit ceiling; coin that would exceed it is rejected
//  PRICES        {8'd6,8'd5,8'd4,8'd3} packed; product i price = PRICES[i*CREDIT_W +: CREDIT_W]
//  DISPENSE_CYC  200                cycles dispense[i] is held high
//  TIMEOUT_CYC   1000               idle cycles in CREDIT before automatic refund
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous, active-high reset
//  coin_lo      in   1         one-cycle pulse: low coin inserted (value 1)
//  coin_hi      in   1         one-cycle pulse: high coin inserted (value COIN_HI_VAL)
//  cancel       in   1         level; request refund of current credit
//  sel          in   N_PROD    product select levels; valid only when exactly one bit set
//  credit       out  CREDIT_W  current credit (display)
//  dispense     out  N_PROD    one-hot, active while vending product i
//  coin_reject  out  1         one-cycle pulse: inserted coin(s) returned
//  short_credit out  1         one-cycle pulse: valid sel but credit < price
//  change_lo    out  1         one-cycle pulse: eject one low coin
//  change_hi    out  1         one-cycle pulse: eject one high coin
//  busy         out  1         high in DISPENSE or CHANGE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; credit, timer, latched product cleared. Reset mid-vend aborts,
//   credit is lost (no refund). All outputs registered.
//  IDLE: any coin -> CREDIT with credit=coin sum. sel/cancel ignored.
//  CREDIT:
//   - coins: add coin_lo + coin_hi*COIN_HI_VAL (both same cycle summed). If sum > MAX_CREDIT whole
//     cycle's coins rejected, coin_reject=1 next cycle, credit unchanged. Any accepted coin, sel or
//     cancel reloads timeout counter.
//   - sel one-hot, credit >= price: latch product, credit -= price, -> DISPENSE. Coin in same cycle
//     is added after comparison (compare uses pre-coin credit).
//   - sel one-hot, credit < price: short_credit pulse, stay. sel multi-hot or zero: no action.
//   - cancel (priority over sel): -> CHANGE with change = credit + same-cycle accepted coins.
//   - timer reaches TIMEOUT_CYC: -> CHANGE (refund as cancel).
//  DISPENSE: dispense[prod]=1 first cycle after entry for exactly DISPENSE_CYC cycles. Coins rejected
//   (coin_reject pulse); sel/cancel ignored. Then -> CHANGE if credit>0 else IDLE.
//  CHANGE: remaining=credit; each pair of cycles emits one pulse then one gap: change_hi if
//   remaining>=COIN_HI_VAL else change_lo; remaining decremented accordingly; credit tracks
//   remaining. Coins rejected. remaining==0 -> IDLE. Never both change pulses in one cycle.
//  Arithmetic: credit unsigned CREDIT_W; MAX_CREDIT must be < 2**CREDIT_W - COIN_HI_VAL - 1
//   so the add never wraps; prices > MAX_CREDIT make the product unvendable (always short_credit).
// STRUCTURE
//  vend_pkg: state encoding (IDLE, CREDIT, DISPENSE, CHANGE), price-extract function,
//   one-hot check function.
//  Sub-module vend_change_dispenser: load/remaining/pulse generator for CHANGE; done flag to FSM.
//  Top: state FSM, credit register, timeout and dispense counters.
// TESTING
//  1) reset; coin_hi, coin_lo; sel=4'b0100 (price 5) -> credit 6->1, dispense[2] 200 cyc,
//     then one change_lo, IDLE, credit 0.
//  2) 3x coin_lo; sel=4'b1000 (price 6) -> short_credit pulse, credit stays 3; cancel ->
//     change_lo x3 on alternate cycles, then IDLE.
//  3) credit 97; coin_hi -> coin_reject, credit 97; coin_lo+coin_hi same cycle at credit 10 -> 16.
//  4) coin_lo, then no input TIMEOUT_CYC cycles -> CHANGE, one change_lo, IDLE.
//  5) credit 12, sel=4'b0001 and cancel same cycle -> cancel wins: change_hi,change_hi,change_lo,
//     change_lo, no dispense; sel=4'b0011 at credit 12 -> no action.
//  6) assert reset during DISPENSE -> all outputs 0 immediately, IDLE, credit 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller: FSM state encoding,
// price-table extraction and one-hot selection check.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_e;

    // Widest packed price table the extract helper accepts.
    localparam int PRICE_VEC_W = 512;

    function automatic logic [31:0] price_extract(input logic [PRICE_VEC_W-1:0] prices,
                                                  input int idx,
                                                  input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return 32'(prices >> (idx * width)) & mask;
    endfunction

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Change ejector: loads an amount, then emits one coin pulse every other cycle,
// largest coin first, until nothing remains.
module vend_change_dispenser #(
    parameter int CREDIT_W    = 8,
    parameter int COIN_HI_VAL = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [CREDIT_W-1:0] load_val_i,
    input  logic                active_i,
    output logic                change_lo_o,
    output logic                change_hi_o,
    output logic [CREDIT_W-1:0] next_remaining_o,
    output logic                done_o
);

    logic [CREDIT_W-1:0] remaining_q, remaining_d;
    logic                phase_q, phase_d;
    logic                change_lo_q, change_lo_d;
    logic                change_hi_q, change_hi_d;

    always_comb begin
        remaining_d = remaining_q;
        phase_d     = phase_q;
        change_lo_d = 1'b0;
        change_hi_d = 1'b0;
        if (load_i) begin
            remaining_d = load_val_i;
            phase_d     = 1'b0;
        end else if (active_i) begin
            // phase_q high marks the mandatory gap cycle after each pulse
            if (phase_q) begin
                phase_d = 1'b0;
            end else if (remaining_q != '0) begin
                phase_d = 1'b1;
                if (remaining_q >= CREDIT_W'(COIN_HI_VAL)) begin
                    change_hi_d = 1'b1;
                    remaining_d = remaining_q - CREDIT_W'(COIN_HI_VAL);
                end else begin
                    change_lo_d = 1'b1;
                    remaining_d = remaining_q - CREDIT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_q <= '0;
            phase_q     <= 1'b0;
            change_lo_q <= 1'b0;
            change_hi_q <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            change_lo_q <= change_lo_d;
            change_hi_q <= change_hi_d;
        end
    end

    assign change_lo_o      = change_lo_q;
    assign change_hi_o      = change_hi_q;
    assign next_remaining_o = remaining_d;
    assign done_o           = (remaining_q == '0);

endmodule

// File: rtl/vend_controller.sv
// Multi-product vending controller: accumulates saturating coin credit, vends by
// price, and refunds leftover credit as coins on vend, cancel or inactivity.
module vend_controller
    import vend_pkg::*;
#(
    parameter int                        N_PROD       = 4,
    parameter int                        CREDIT_W     = 8,
    parameter int                        COIN_HI_VAL  = 5,
    parameter int                        MAX_CREDIT   = 99,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES      = {8'd6, 8'd5, 8'd4, 8'd3},
    parameter int                        DISPENSE_CYC = 200,
    parameter int                        TIMEOUT_CYC  = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_lo,
    input  logic                coin_hi,
    input  logic                cancel,
    input  logic [N_PROD-1:0]   sel,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_PROD-1:0]   dispense,
    output logic                coin_reject,
    output logic                short_credit,
    output logic                change_lo,
    output logic                change_hi,
    output logic                busy
);

    localparam int SUM_W  = CREDIT_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int DCNT_W = $clog2(DISPENSE_CYC + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DISPENSE_CYC - 1);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [DCNT_W-1:0]   disp_cnt_q, disp_cnt_d;
    logic [N_PROD-1:0]   prod_q, prod_d;
    logic [N_PROD-1:0]   dispense_q, dispense_d;
    logic                coin_reject_q, coin_reject_d;
    logic                short_credit_q, short_credit_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W-1:0] price [N_PROD];
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_onehot;
    logic [SUM_W-1:0]    coin_sum, credit_plus;
    logic                any_coin, coin_ok, activity;
    logic [CREDIT_W-1:0] accepted, credit_acc;

    logic                chg_load, chg_done;
    logic [CREDIT_W-1:0] chg_load_val, chg_next_remaining;

    for (genvar gi = 0; gi < N_PROD; gi++) begin : g_price
        assign price[gi] = CREDIT_W'(price_extract(PRICE_VEC_W'(PRICES), gi, CREDIT_W));
    end

    always_comb begin
        sel_price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel[i]) sel_price = price[i];
        end
    end

    // Overflow is judged against pre-coin credit; the extra bit keeps the sum from wrapping.
    assign sel_onehot  = is_onehot(32'(sel));
    assign any_coin    = coin_lo | coin_hi;
    assign coin_sum    = SUM_W'(coin_lo) + (coin_hi ? SUM_W'(COIN_HI_VAL) : SUM_W'(0));
    assign credit_plus = {1'b0, credit_q} + coin_sum;
    assign coin_ok     = (credit_plus <= SUM_W'(MAX_CREDIT));
    assign accepted    = coin_ok ? coin_sum[CREDIT_W-1:0] : '0;
    assign credit_acc  = credit_q + accepted;
    assign activity    = (any_coin && coin_ok) || (sel != '0) || cancel;

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        timer_d        = timer_q;
        disp_cnt_d     = disp_cnt_q;
        prod_d         = prod_q;
        dispense_d     = '0;
        coin_reject_d  = 1'b0;
        short_credit_d = 1'b0;
        chg_load       = 1'b0;
        chg_load_val   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_coin) begin
                    state_d  = ST_CREDIT;
                    credit_d = coin_sum[CREDIT_W-1:0];
                    timer_d  = '0;
                end
            end
            ST_CREDIT: begin
                coin_reject_d = any_coin && !coin_ok;
                if (cancel) begin
                    state_d      = ST_CHANGE;
                    chg_load     = 1'b1;
                    chg_load_val = credit_acc;
                    credit_d     = credit_acc;
                end else if (sel_onehot && (credit_q >= sel_price)) begin
                    state_d    = ST_DISPENSE;
                    prod_d     = sel;
                    dispense_d = sel;
                    disp_cnt_d = '0;
                    credit_d   = credit_acc - sel_price;
                end else begin
                    short_credit_d = sel_onehot;
                    credit_d       = credit_acc;
                    if (activity) begin
                        timer_d = '0;
                    end else if (timer_q == TMR_LAST) begin
                        state_d      = ST_CHANGE;
                        chg_load     = 1'b1;
                        chg_load_val = credit_q;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = any_coin;
                if (disp_cnt_q == DCNT_LAST) begin
                    if (credit_q != '0) begin
                        state_d      = ST_CHANGE;
                        chg_load     = 1'b1;
                        chg_load_val = credit_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    disp_cnt_d = disp_cnt_q + DCNT_W'(1);
                    dispense_d = prod_q;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = any_coin;
                credit_d      = chg_next_remaining;
                if (chg_done) begin
                    state_d  = ST_IDLE;
                    credit_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            timer_q        <= '0;
            disp_cnt_q     <= '0;
            prod_q         <= '0;
            dispense_q     <= '0;
            coin_reject_q  <= 1'b0;
            short_credit_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            timer_q        <= timer_d;
            disp_cnt_q     <= disp_cnt_d;
            prod_q         <= prod_d;
            dispense_q     <= dispense_d;
            coin_reject_q  <= coin_reject_d;
            short_credit_q <= short_credit_d;
            busy_q         <= busy_d;
        end
    end

    vend_change_dispenser #(
        .CREDIT_W    (CREDIT_W),
        .COIN_HI_VAL (COIN_HI_VAL)
    ) u_change (
        .clk              (clk),
        .reset            (reset),
        .load_i           (chg_load),
        .load_val_i       (chg_load_val),
        .active_i         (state_q == ST_CHANGE),
        .change_lo_o      (change_lo),
        .change_hi_o      (change_hi),
        .next_remaining_o (chg_next_remaining),
        .done_o           (chg_done)
    );

    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign coin_reject  = coin_reject_q;
    assign short_credit = short_credit_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Scenario and randomized bench for vend_controller; expected values come from
// plain credit arithmetic (greedy change = credit/5 high coins then credit%5 low coins).
module tb_vend_controller;

    localparam int N_PROD   = 4;
    localparam int CREDIT_W = 8;
    localparam int HI       = 5;
    localparam int MAXC     = 99;
    localparam int DCYC     = 200;
    localparam int TCYC     = 1000;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                coin_lo = 1'b0, coin_hi = 1'b0, cancel = 1'b0;
    logic [N_PROD-1:0]   sel = '0;
    logic [CREDIT_W-1:0] credit;
    logic [N_PROD-1:0]   dispense;
    logic                coin_reject, short_credit, change_lo, change_hi, busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    vend_controller #(
        .N_PROD       (N_PROD),
        .CREDIT_W     (CREDIT_W),
        .COIN_HI_VAL  (HI),
        .MAX_CREDIT   (MAXC),
        .PRICES       ({8'd6, 8'd5, 8'd4, 8'd3}),
        .DISPENSE_CYC (DCYC),
        .TIMEOUT_CYC  (TCYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_lo      (coin_lo),
        .coin_hi      (coin_hi),
        .cancel       (cancel),
        .sel          (sel),
        .credit       (credit),
        .dispense     (dispense),
        .coin_reject  (coin_reject),
        .short_credit (short_credit),
        .change_lo    (change_lo),
        .change_hi    (change_hi),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Product i costs 3+i low coins.
    function automatic int price_of(input logic [3:0] s);
        return 3 + $clog2(s);
    endfunction

    // Apply inputs for one clock, then sample 1 ns after the edge.
    task automatic cyc(input logic lo, input logic hi, input logic cn, input logic [3:0] s);
        coin_lo = lo; coin_hi = hi; cancel = cn; sel = s;
        @(posedge clk); #1;
        coin_lo = 1'b0; coin_hi = 1'b0; cancel = 1'b0; sel = '0;
    endtask

    task automatic watch_dispense(output int width, output logic [3:0] first_val,
                                  output int n_var, output bit tmo);
        width = 0; n_var = 0; first_val = dispense;
        while (dispense != 4'b0 && width < 4 * DCYC) begin
            if (dispense !== first_val) n_var++;
            width++;
            @(posedge clk); #1;
        end
        tmo = (dispense != 4'b0);
    endtask

    // Observes refund until busy drops; n_bad counts spacing/order/overlap/credit-tracking anomalies.
    task automatic watch_change(input int start, output int n_hi, output int n_lo,
                                output int n_bad, output int n_disp, output bit tmo);
        int idx, last, rem;
        n_hi = 0; n_lo = 0; n_bad = 0; n_disp = 0; idx = 0; last = -1; rem = start;
        while (busy === 1'b1 && idx < 400) begin
            if (change_hi && change_lo) n_bad++;
            if (change_hi || change_lo) begin
                if (last >= 0 && idx - last != 2) n_bad++;
                last = idx;
            end
            if (change_hi) begin n_hi++; rem -= HI; if (n_lo > 0) n_bad++; end
            if (change_lo) begin n_lo++; rem -= 1; end
            if (credit !== 8'(rem)) n_bad++;
            if (dispense != 4'b0) n_disp++;
            idx++;
            @(posedge clk); #1;
        end
        tmo = (busy === 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if ({credit, dispense, coin_reject, short_credit, change_lo, change_hi, busy} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: credit=%0d dispense=%b busy=%b, want all zero", credit, dispense, busy);
        end
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 4'b0001);
        vec_cnt++;
        if (credit !== 8'd0 || busy !== 1'b0 || short_credit !== 1'b0 || dispense !== 4'b0) begin
            err_cnt++;
            $display("FAIL idle_ignores_sel_cancel: credit=%0d busy=%b short=%b, want 0 0 0", credit, busy, short_credit);
        end
    endtask

    task automatic test_vend_basic();
        int w, nv, nh, nl, nb, nd; logic [3:0] fv; bit tmo;
        cyc(1'b0, 1'b1, 1'b0, 4'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'b0);
        vec_cnt++;
        if (credit !== 8'd6) begin err_cnt++; $display("FAIL basic_credit: got %0d want 6", credit); end
        cyc(1'b0, 1'b0, 1'b0, 4'b0100);
        vec_cnt++;
        if (dispense !== 4'b0100 || credit !== 8'd1 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_vend_start: dispense=%b credit=%0d busy=%b, want 0100 1 1", dispense, credit, busy);
        end
        cyc(1'b0, 1'b1, 1'b0, 4'b0);
        vec_cnt++;
        if (coin_reject !== 1'b1 || credit !== 8'd1 || dispense !== 4'b0100) begin
            err_cnt++;
            $display("FAIL basic_coin_in_dispense: reject=%b credit=%0d dispense=%b, want 1 1 0100", coin_reject, credit, dispense);
        end
        watch_dispense(w, fv, nv, tmo);
        vec_cnt++;
        if (w + 1 != DCYC || nv != 0 || tmo) begin
            err_cnt++;
            $display("FAIL basic_dispense_width: width=%0d var=%0d tmo=%0d, want %0d 0 0", w + 1, nv, tmo, DCYC);
        end
        watch_change(1, nh, nl, nb, nd, tmo);
        vec_cnt++;
        if (nh != 0 || nl != 1 || nb != 0 || tmo || credit !== 8'd0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_change: hi=%0d lo=%0d bad=%0d tmo=%0d credit=%0d, want 0 1 0 0 0", nh, nl, nb, tmo, credit);
        end
    endtask

    task automatic test_short_cancel();
        int nh, nl, nb, nd; bit tmo;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 4'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'b1000);
        vec_cnt++;
        if (short_credit !== 1'b1 || credit !== 8'd3 || dispense !== 4'b0) begin
            err_cnt++;
            $display("FAIL short_pulse: short=%b credit=%0d dispense=%b, want 1 3 0000", short_credit, credit, dispense);
        end
        cyc(1'b0, 1'b0, 1'b0, 4'b0);
        vec_cnt++;
        if (short_credit !== 1'b0) begin err_cnt++; $display("FAIL short_one_cycle: short=%b want 0", short_credit); end
        cyc(1'b0, 1'b0, 1'b1, 4'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'b0);
        vec_cnt++;
        if (coin_reject !== 1'b1 || change_lo !== 1'b1 || credit !== 8'd2) begin
            err_cnt++;
            $display("FAIL change_coin_reject: reject=%b lo=%b credit=%0d, want 1 1 2", coin_reject, change_lo, credit);
        end
        watch_change(3, nh, nl, nb, nd, tmo);
        vec_cnt++;
        if (nh != 0 || nl != 3 || nb != 0 || tmo || credit !== 8'd0) begin
            err_cnt++;
            $display("FAIL cancel_change: hi=%0d lo=%0d bad=%0d tmo=%0d credit=%0d, want 0 3 0 0 0", nh, nl, nb, tmo, credit);
        end
    endtask

    task automatic test_reject();
        int nh, nl, nb, nd; bit tmo;
        repeat (19) cyc(1'b0, 1'b1, 1'b0, 4'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 4'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'b0);
        vec_cnt++;
        if (coin_reject !== 1'b1 || credit !== 8'd97) begin
            err_cnt++;
            $display("FAIL reject_hi_at_97: reject=%b credit=%0d, want 1 97", coin_reject, credit);
        end
        cyc(1'b1, 1'b1, 1'b0, 4'b0);
        vec_cnt++;
        if (coin_reject !== 1'b1 || credit !== 8'd97) begin
            err_cnt++;
            $display("FAIL reject_both_at_97: reject=%b credit=%0d, want 1 97", coin_reject, credit);
        end
        cyc(1'b1, 1'b0, 1'b0, 4'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'b0);
        vec_cnt++;
        if (coin_reject !== 1'b0 || credit !== 8'd99) begin
            err_cnt++;
            $display("FAIL accept_up_to_max: reject=%b credit=%0d, want 0 99", coin_reject, credit);
        end
        cyc(1'b1, 1'b0, 1'b0, 4'b0);
        vec_cnt++;
        if (coin_reject !== 1'b1 || credit !== 8'd99) begin
            err_cnt++;
            $display("FAIL reject_lo_at_max: reject=%b credit=%0d, want 1 99", coin_reject, credit);
        end
        cyc(1'b0, 1'b0, 1'b1, 4'b0);
        watch_change(99, nh, nl, nb, nd, tmo);
        vec_cnt++;
        if (nh != 19 || nl != 4 || nb != 0 || tmo) begin
            err_cnt++;
            $display("FAIL change_99: hi=%0d lo=%0d bad=%0d tmo=%0d, want 19 4 0 0", nh, nl, nb, tmo);
        end
        cyc(1'b0, 1'b1, 1'b0, 4'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'b0);
        cyc(1'b1, 1'b1, 1'b0, 4'b0);
        vec_cnt++;
        if (coin_reject !== 1'b0 || credit !== 8'd16) begin
            err_cnt++;
            $display("FAIL both_coins_sum: reject=%b credit=%0d, want 0 16", coin_reject, credit);
        end
        cyc(1'b0, 1'b0, 1'b1, 4'b0);
        watch_change(16, nh, nl, nb, nd, tmo);
        vec_cnt++;
        if (nh != 3 || nl != 1 || nb != 0 || tmo) begin
            err_cnt++;
            $display("FAIL change_16: hi=%0d lo=%0d bad=%0d tmo=%0d, want 3 1 0 0", nh, nl, nb, tmo);
        end
    endtask

    task automatic test_timeout();
        int k, nh, nl, nb, nd; bit tmo;
        cyc(1'b1, 1'b0, 1'b0, 4'b0);
        repeat (600) cyc(1'b0, 1'b0, 1'b0, 4'b0);
        vec_cnt++;
        if (busy !== 1'b0 || credit !== 8'd1) begin
            err_cnt++;
            $display("FAIL timeout_early: busy=%b credit=%0d, want 0 1", busy, credit);
        end
        cyc(1'b1, 1'b0, 1'b0, 4'b0);
        k = 0;
        while (busy !== 1'b1 && k < 2 * TCYC) begin
            cyc(1'b0, 1'b0, 1'b0, 4'b0);
            k++;
        end
        vec_cnt++;
        if (k != TCYC) begin err_cnt++; $display("FAIL timeout_cycles: got %0d want %0d", k, TCYC); end
        watch_change(2, nh, nl, nb, nd, tmo);
        vec_cnt++;
        if (nh != 0 || nl != 2 || nb != 0 || tmo || credit !== 8'd0) begin
            err_cnt++;
            $display("FAIL timeout_refund: hi=%0d lo=%0d bad=%0d tmo=%0d credit=%0d, want 0 2 0 0 0", nh, nl, nb, tmo, credit);
        end
    endtask

    task automatic test_cancel_priority();
        int nh, nl, nb, nd; bit tmo;
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 4'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 4'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'b0001);
        watch_change(12, nh, nl, nb, nd, tmo);
        vec_cnt++;
        if (nh != 2 || nl != 2 || nb != 0 || nd != 0 || tmo) begin
            err_cnt++;
            $display("FAIL cancel_beats_sel: hi=%0d lo=%0d bad=%0d disp=%0d tmo=%0d, want 2 2 0 0 0", nh, nl, nb, nd, tmo);
        end
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 4'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 4'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'b0011);
        vec_cnt++;
        if (credit !== 8'd12 || short_credit !== 1'b0 || busy !== 1'b0 || dispense !== 4'b0) begin
            err_cnt++;
            $display("FAIL multihot_no_action: credit=%0d short=%b busy=%b, want 12 0 0", credit, short_credit, busy);
        end
        cyc(1'b0, 1'b0, 1'b1, 4'b0);
        watch_change(12, nh, nl, nb, nd, tmo);
    endtask

    task automatic test_reset_mid_vend();
        cyc(1'b0, 1'b1, 1'b0, 4'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'b0001);
        vec_cnt++;
        if (dispense !== 4'b0001 || credit !== 8'd2) begin
            err_cnt++;
            $display("FAIL pre_reset_vend: dispense=%b credit=%0d, want 0001 2", dispense, credit);
        end
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 4'b0);
        #2 reset = 1'b1;
        #1;
        vec_cnt++;
        if ({credit, dispense, coin_reject, short_credit, change_lo, change_hi, busy} !== '0) begin
            err_cnt++;
            $display("FAIL async_reset_mid_vend: credit=%0d dispense=%b busy=%b, want all zero", credit, dispense, busy);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'b0);
        vec_cnt++;
        if (credit !== 8'd0 || busy !== 1'b0 || dispense !== 4'b0 || change_lo !== 1'b0) begin
            err_cnt++;
            $display("FAIL post_reset_idle: credit=%0d busy=%b dispense=%b, want 0 0 0000", credit, busy, dispense);
        end
        cyc(1'b1, 1'b0, 1'b0, 4'b0);
        vec_cnt++;
        if (credit !== 8'd1) begin err_cnt++; $display("FAIL post_reset_coin: credit=%0d want 1", credit); end
        cyc(1'b0, 1'b0, 1'b1, 4'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 4'b0);
    endtask

    task automatic test_random();
        int cr, n, r, sum, acc, exp_rej, ch, w, nv, nh, nl, nb, nd;
        logic lo, hi; logic [3:0] s, fv, exp_disp; bit vended, tmo, exp_short;
        for (int round = 0; round < 8; round++) begin
            cr = 0;
            n = $urandom_range(2, 24);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(1, 3); lo = r[0]; hi = r[1];
                sum = int'(lo) + HI * int'(hi);
                if (i == 0) begin cr = sum; exp_rej = 0; end
                else if (cr + sum > MAXC) exp_rej = 1;
                else begin cr += sum; exp_rej = 0; end
                cyc(lo, hi, 1'b0, 4'b0);
                vec_cnt++;
                if (credit !== 8'(cr) || coin_reject !== exp_rej[0]) begin
                    err_cnt++;
                    $display("FAIL rnd_coin r%0d i%0d: credit=%0d reject=%b, want %0d %0d", round, i, credit, coin_reject, cr, exp_rej);
                end
            end
            vended = 0;
            for (int t = 0; t < 4 && !vended; t++) begin
                s = 4'($urandom_range(0, 15)); r = $urandom_range(0, 3); lo = r[0]; hi = r[1];
                sum = int'(lo) + HI * int'(hi);
                acc = (cr + sum <= MAXC) ? sum : 0;
                exp_rej = (sum > 0 && acc == 0) ? 1 : 0;
                exp_disp = 4'b0; exp_short = 1'b0;
                if ($countones(s) == 1 && cr >= price_of(s)) begin
                    vended = 1; cr = cr - price_of(s) + acc; exp_disp = s;
                end else begin
                    exp_short = ($countones(s) == 1); cr += acc;
                end
                cyc(lo, hi, 1'b0, s);
                vec_cnt++;
                if (credit !== 8'(cr) || dispense !== exp_disp || short_credit !== exp_short || coin_reject !== exp_rej[0]) begin
                    err_cnt++;
                    $display("FAIL rnd_sel r%0d sel=%b: credit=%0d disp=%b short=%b rej=%b, want %0d %b %b %0d",
                             round, s, credit, dispense, short_credit, coin_reject, cr, exp_disp, exp_short, exp_rej);
                end
            end
            if (vended) begin
                watch_dispense(w, fv, nv, tmo);
                vec_cnt++;
                if (w != DCYC || nv != 0 || tmo) begin
                    err_cnt++;
                    $display("FAIL rnd_dispense r%0d: width=%0d var=%0d tmo=%0d, want %0d 0 0", round, w, nv, tmo, DCYC);
                end
                ch = cr;
            end else begin
                r = $urandom_range(0, 3); lo = r[0]; hi = r[1];
                sum = int'(lo) + HI * int'(hi);
                acc = (cr + sum <= MAXC) ? sum : 0;
                ch = cr + acc;
                cyc(lo, hi, 1'b1, 4'($urandom_range(0, 15)));
                vec_cnt++;
                if (busy !== 1'b1 || credit !== 8'(ch) || dispense !== 4'b0) begin
                    err_cnt++;
                    $display("FAIL rnd_cancel r%0d: busy=%b credit=%0d disp=%b, want 1 %0d 0000", round, busy, credit, dispense, ch);
                end
            end
            watch_change(ch, nh, nl, nb, nd, tmo);
            vec_cnt++;
            if (nh != ch / HI || nl != ch % HI || nb != 0 || tmo || credit !== 8'd0 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL rnd_change r%0d amt=%0d: hi=%0d lo=%0d bad=%0d tmo=%0d credit=%0d, want %0d %0d 0 0 0",
                         round, ch, nh, nl, nb, tmo, credit, ch / HI, ch % HI);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vend_basic();
        test_short_cancel();
        test_reject();
        test_timeout();
        test_cancel_priority();
        test_reset_mid_vend();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached after %0d vectors", vec_cnt);
        $fatal(1, "watchdog");
    end

endmodule
